// File: rtl/joypad_ctrl_if.sv
// CPU bus bundle shared between the CPU model and memory-mapped peripherals.
// The CPU side drives address, write data and strobes; the peripheral side
// answers with read data.
interface Bus_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        write_en;
    logic        read_en;
    logic [7:0]  rdata;

    modport Cpu_side (
        output addr,
        output wdata,
        output write_en,
        output read_en,
        input  rdata
    );

    modport Peripheral_side (
        input  addr,
        input  wdata,
        input  write_en,
        input  read_en,
        output rdata
    );
endinterface

// File: rtl/joypad_ctrl.sv
// Joypad controller: synchronizes and debounces eight button pads, exposes
// them through the P1 register at FF00 (two select lines picking the
// direction and/or action group) and raises a one-cycle interrupt whenever
// any visible nibble bit falls from 1 to 0.
module joypad_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           buttons_raw,
    Bus_if.Peripheral_side       bus,
    output logic                 irq_joypad,
    output logic [7:0]           buttons_stable
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [15:0]     P1_ADDR  = 16'hFF00;

    logic [7:0]    sync_meta;
    logic [7:0]    sync_out;
    logic [CW-1:0] cnt [8];
    logic [1:0]    sel;
    logic [3:0]    nib;
    logic [3:0]    prev_nib;
    logic          p1_write;
    logic          p1_read;
    logic          unused_wdata_bits;

    // Only bits 5:4 of a P1 write carry meaning; the rest are dropped.
    assign unused_wdata_bits = ^{bus.wdata[7:6], bus.wdata[3:0]};

    assign p1_write = bus.write_en && (bus.addr == P1_ADDR);
    assign p1_read  = bus.read_en  && (bus.addr == P1_ADDR);

    // Two-flop synchronizer per pad bit; nothing downstream sees raw levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= buttons_raw;
            sync_out  <= sync_meta;
        end
    end

    // Per-bit debounce: count consecutive mismatch cycles, commit the new
    // level once the count has reached DEBOUNCE_CYCLES and is still mismatched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buttons_stable <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (sync_out[i] == buttons_stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    buttons_stable[i] <= sync_out[i];
                    cnt[i]            <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Select register; a write lands on the edge so a same-cycle read still
    // returns the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel <= 2'b11;
        end else if (p1_write) begin
            sel <= bus.wdata[5:4];
        end
    end

    // Active-low nibble: a selected group with a pressed button pulls its bit low.
    always_comb begin
        nib = ~(((sel[0] == 1'b0) ? buttons_stable[3:0] : 4'h0) |
                ((sel[1] == 1'b0) ? buttons_stable[7:4] : 4'h0));
    end

    // Combinational read mux; unmapped or idle accesses float high.
    always_comb begin
        bus.rdata = 8'hFF;
        if (p1_read) begin
            bus.rdata = {2'b11, sel, nib};
        end
    end

    // Falling-edge detector on the visible nibble; several bits falling at
    // once collapse into a single pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_nib   <= 4'hF;
            irq_joypad <= 1'b0;
        end else begin
            prev_nib   <= nib;
            irq_joypad <= |(prev_nib & ~nib);
        end
    end

endmodule

// File: tb/tb_joypad_ctrl.sv
// Directed testbench for joypad_ctrl with DEBOUNCE_CYCLES = 4, so a clean
// pad edge reaches buttons_stable 6 cycles after the first sampling edge.
module tb_joypad_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] buttons_raw;
    logic       irq_joypad;
    logic [7:0] buttons_stable;
    int         checks;
    int         failures;

    Bus_if bus_i ();

    joypad_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .buttons_raw    (buttons_raw),
        .bus            (bus_i),
        .irq_joypad     (irq_joypad),
        .buttons_stable (buttons_stable)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus_i.addr     = 16'h0000;
        bus_i.wdata    = 8'h00;
        bus_i.write_en = 1'b0;
        bus_i.read_en  = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus_i.addr     = a;
        bus_i.wdata    = d;
        bus_i.write_en = 1'b1;
        tick();
        bus_i.write_en = 1'b0;
    endtask

    task automatic do_reset();
        bus_idle();
        buttons_raw = 8'h00;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus_idle();
        buttons_raw = 8'h00;
        reset = 1'b0;
        tick();
        bus_i.addr = 16'hFF00;
        bus_i.read_en = 1'b1;
        #1;
        checks++;
        if (bus_i.rdata !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL reset_rdata got=%h want=ff", bus_i.rdata);
        end
        checks++;
        if (buttons_stable !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_stable got=%h want=00", buttons_stable);
        end
        checks++;
        if (irq_joypad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_irq got=%b want=0", irq_joypad);
        end
        bus_i.read_en = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (irq_joypad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release_irq got=%b want=0", irq_joypad);
        end
    endtask

    task automatic test_debounce_latency();
        do_reset();
        bus_write(16'hFF00, 8'h20);
        buttons_raw = 8'h01;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (buttons_stable[0] !== (k >= 7)) begin
                failures++;
                $display("[TB] FAIL latency_stable edge=%0d got=%b want=%b", k, buttons_stable[0], (k >= 7));
            end
            checks++;
            if (irq_joypad !== 1'b0) begin
                failures++;
                $display("[TB] FAIL latency_irq_early edge=%0d got=%b want=0", k, irq_joypad);
            end
        end
        bus_i.addr = 16'hFF00;
        bus_i.read_en = 1'b1;
        #1;
        checks++;
        if (bus_i.rdata !== 8'hEE) begin
            failures++;
            $display("[TB] FAIL latency_read got=%h want=ee", bus_i.rdata);
        end
        bus_i.read_en = 1'b0;
        tick();
        checks++;
        if (irq_joypad !== 1'b1) begin
            failures++;
            $display("[TB] FAIL latency_irq_pulse got=%b want=1", irq_joypad);
        end
        tick();
        checks++;
        if (irq_joypad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_irq_end got=%b want=0", irq_joypad);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        bus_write(16'hFF00, 8'h00);
        buttons_raw = 8'h10;
        tick();
        tick();
        tick();
        buttons_raw = 8'h00;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (buttons_stable !== 8'h00 || irq_joypad !== 1'b0) begin
                failures++;
                $display("[TB] FAIL glitch cycle=%0d stable=%h irq=%b want stable=00 irq=0", k, buttons_stable, irq_joypad);
            end
        end
    endtask

    task automatic test_sel_write();
        do_reset();
        buttons_raw = 8'h10;
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (buttons_stable !== 8'h10) begin
            failures++;
            $display("[TB] FAIL selw_stable got=%h want=10", buttons_stable);
        end
        bus_i.addr = 16'hFF00;
        bus_i.read_en = 1'b1;
        #1;
        checks++;
        if (bus_i.rdata !== 8'hFF || irq_joypad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL selw_read_before got=%h irq=%b want=ff irq=0", bus_i.rdata, irq_joypad);
        end
        bus_i.wdata = 8'h10;
        bus_i.write_en = 1'b1;
        #1;
        checks++;
        if (bus_i.rdata !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL selw_same_cycle_read got=%h want=ff", bus_i.rdata);
        end
        tick();
        bus_i.write_en = 1'b0;
        #1;
        checks++;
        if (bus_i.rdata !== 8'hDE || irq_joypad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL selw_read_after got=%h irq=%b want=de irq=0", bus_i.rdata, irq_joypad);
        end
        bus_i.read_en = 1'b0;
        tick();
        checks++;
        if (irq_joypad !== 1'b1) begin
            failures++;
            $display("[TB] FAIL selw_irq_pulse got=%b want=1", irq_joypad);
        end
        tick();
        checks++;
        if (irq_joypad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL selw_irq_end got=%b want=0", irq_joypad);
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        do_reset();
        bus_write(16'hFF00, 8'h00);
        buttons_raw = 8'h11;
        for (int k = 0; k < 7; k++) tick();
        bus_i.addr = 16'hFF00;
        bus_i.read_en = 1'b1;
        #1;
        checks++;
        if (bus_i.rdata !== 8'hCE || buttons_stable !== 8'h11) begin
            failures++;
            $display("[TB] FAIL simul_read got=%h stable=%h want=ce stable=11", bus_i.rdata, buttons_stable);
        end
        bus_i.read_en = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (irq_joypad === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("[TB] FAIL simul_press_pulses got=%0d want=1", pulses);
        end
        buttons_raw = 8'h00;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (irq_joypad === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("[TB] FAIL simul_release_pulses got=%0d want=0", pulses);
        end
        bus_i.addr = 16'hFF00;
        bus_i.read_en = 1'b1;
        #1;
        checks++;
        if (bus_i.rdata !== 8'hCF) begin
            failures++;
            $display("[TB] FAIL simul_release_read got=%h want=cf", bus_i.rdata);
        end
        bus_i.read_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        buttons_raw = 8'h12;
        for (int k = 0; k < 8; k++) tick();
        bus_i.addr = 16'hFF00;
        bus_i.write_en = 1'b1;
        bus_i.wdata = 8'h20;
        tick();
        checks++;
        if (irq_joypad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_first_edge got=%b want=0", irq_joypad);
        end
        bus_i.wdata = 8'h00;
        tick();
        bus_i.write_en = 1'b0;
        checks++;
        if (irq_joypad !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_pulse1 got=%b want=1", irq_joypad);
        end
        tick();
        checks++;
        if (irq_joypad !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_pulse2 got=%b want=1", irq_joypad);
        end
        tick();
        checks++;
        if (irq_joypad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_end got=%b want=0", irq_joypad);
        end
    endtask

    task automatic test_other_addr();
        do_reset();
        bus_write(16'hFF01, 8'h00);
        bus_write(16'hFE00, 8'h00);
        bus_i.addr = 16'hFF01;
        bus_i.read_en = 1'b1;
        #1;
        checks++;
        if (bus_i.rdata !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL other_read got=%h want=ff", bus_i.rdata);
        end
        bus_i.addr = 16'hFF00;
        #1;
        checks++;
        if (bus_i.rdata !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL other_sel_kept got=%h want=ff", bus_i.rdata);
        end
        bus_i.read_en = 1'b0;
        bus_write(16'hFF00, 8'hCF);
        #1;
        checks++;
        if (bus_i.rdata !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL no_read_en got=%h want=ff", bus_i.rdata);
        end
        bus_i.addr = 16'hFF00;
        bus_i.read_en = 1'b1;
        #1;
        checks++;
        if (bus_i.rdata !== 8'hCF) begin
            failures++;
            $display("[TB] FAIL masked_wdata got=%h want=cf", bus_i.rdata);
        end
        bus_i.read_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus_write(16'hFF00, 8'h00);
        buttons_raw = 8'h10;
        for (int k = 0; k < 9; k++) tick();
        buttons_raw = 8'h11;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (buttons_stable !== 8'h10) begin
            failures++;
            $display("[TB] FAIL mid_pre_stable got=%h want=10", buttons_stable);
        end
        reset = 1'b0;
        bus_i.addr = 16'hFF00;
        bus_i.read_en = 1'b1;
        #1;
        checks++;
        if (buttons_stable !== 8'h00 || irq_joypad !== 1'b0 || bus_i.rdata !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL mid_async stable=%h irq=%b rdata=%h want 00 0 ff", buttons_stable, irq_joypad, bus_i.rdata);
        end
        bus_i.read_en = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (buttons_stable !== ((k >= 7) ? 8'h11 : 8'h00)) begin
                failures++;
                $display("[TB] FAIL mid_relatch edge=%0d got=%h want=%h", k, buttons_stable, ((k >= 7) ? 8'h11 : 8'h00));
            end
            if (k == 1) begin
                checks++;
                if (irq_joypad !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL mid_release_irq got=%b want=0", irq_joypad);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        buttons_raw = 8'h00;
        bus_idle();
        test_reset();
        test_debounce_latency();
        test_glitch();
        test_sel_write();
        test_simultaneous();
        test_back_to_back();
        test_other_addr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/joypad_ctrl.md
JOYPAD_CTRL -- requirements
Module: joypad_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16; number of consecutive mismatch cycles before a button's stable state changes; legal range >= 1.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: buttons_raw  input  8  asynchronous pad levels, 1 = pressed.
  - Bit map: 0 right, 1 left, 2 up, 3 down, 4 A, 5 B, 6 select, 7 start.
REQ-005 Port: bus  Bus_if.Peripheral_side  -  CPU bus.
  - Fields used: addr[15:0], wdata[7:0], write_en, read_en, rdata[7:0].
REQ-006 Port: irq_joypad  output  1  joypad interrupt request; one-cycle high pulse.
REQ-007 Port: buttons_stable  output  8  debounced button state, same bit map as buttons_raw.

Function
REQ-008 buttons_raw SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-009 Each bit SHALL have an independent debounce counter, width $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears to 0 in any cycle where the synchronized bit equals buttons_stable.
  - Counter increments in any cycle where the two differ.
  - When the counter reaches DEBOUNCE_CYCLES, the stable bit takes the synchronized value and the counter clears, all in the same edge.
REQ-010 Latency: a clean raw edge SHALL appear on buttons_stable exactly 2 + DEBOUNCE_CYCLES cycles after the first clk edge that samples it.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never reach buttons_stable.
REQ-011 Select register sel[1:0] (P1 bits 5:4) SHALL load wdata[5:4] on a clk edge with write_en=1 and addr=16'hFF00.
  - wdata bits 7:6 and 3:0 are ignored.
REQ-012 Low nibble: nib = ~(((sel[0]==0) ? stable[3:0] : 4'h0) | ((sel[1]==0) ? stable[7:4] : 4'h0)).
  - sel=2'b11 gives nib=4'hF.
  - sel=2'b00 gives the OR of both groups.
REQ-013 Read path is combinational.
  - read_en=1 and addr=16'hFF00: rdata = {2'b11, sel, nib}.
  - Otherwise: rdata = 8'hFF.
REQ-014 Simultaneous read and write to FF00 SHALL return the pre-write sel; the new sel is visible from the next cycle.
REQ-015 A registered copy prev_nib SHALL update every cycle.
  - irq_joypad = 1 for exactly the one cycle after any bit of nib goes 1->0 (any(prev_nib & ~nib) registered).
  - A transition caused by a sel write SHALL also fire.
  - 0->1 transitions SHALL never fire.
REQ-016 Multiple falling bits in the same cycle SHALL produce a single one-cycle pulse.
  - Falls on consecutive cycles SHALL produce back-to-back pulses.
REQ-017 Accesses to any address other than 16'hFF00 SHALL leave all state unchanged and drive rdata = 8'hFF.

Reset
REQ-018 While reset=0, the following SHALL hold asynchronously:
  - sel = 2'b11
  - synchronizer flops, buttons_stable and all debounce counters = 0
  - prev_nib = 4'hF
  - irq_joypad = 0
REQ-019 Reset asserted mid-debounce SHALL discard the partial count.
  - After release, a held button SHALL take the full 2 + DEBOUNCE_CYCLES cycles to appear.
REQ-020 No irq_joypad pulse SHALL occur in the first cycle after reset release.

Verification (DEBOUNCE_CYCLES=4)
REQ-021 Reset, then read FF00 -> rdata=8'hFF; buttons_stable=8'h00; irq_joypad=0.
REQ-022 Write 8'h20 to FF00, hold buttons_raw=8'h01 -> buttons_stable[0]=1 exactly 6 cycles later; read FF00=8'hEE; irq_joypad pulses once, one cycle after nib changes.
REQ-023 buttons_raw[4] high for 3 cycles then low -> buttons_stable stays 8'h00; no irq_joypad.
REQ-024 sel=2'b11 with A held stable -> read FF00=8'hFF; then write 8'h10 -> next read 8'hDE and one irq_joypad pulse from the sel write.
REQ-025 sel=2'b00, right and A pressed in the same cycle -> nib=4'hE; exactly one irq_joypad pulse; release -> no pulse.
REQ-026 Assert reset 2 cycles into a debounce -> all outputs return to reset values immediately; after release the button appears after the full 6 cycles.
